// File: rtl/hazard_controller_if.sv
// Pipeline-to-hazard-controller bundle: stage register fields in, stall/flush/forward controls out.
interface hazard_controller_if #(
  parameter int CNT_W = 32
);
  logic [4:0]       IF_ID_rs1;
  logic [4:0]       IF_ID_rs2;
  logic [4:0]       ID_rs1;
  logic [4:0]       ID_rs2;
  logic [4:0]       ID_EX_RD;
  logic             ID_EX_regwrite;
  logic             ID_EX_wb_sel;
  logic [4:0]       EX_MEM_RD;
  logic             EX_MEM_regwrite;
  logic             EX_MEM_memreq;
  logic             dmem_ready;
  logic [4:0]       MEM_WB_RD;
  logic             MEM_WB_regwrite;
  logic             branch_taken;
  logic             stall_F;
  logic             stall_D;
  logic             stall_E;
  logic             stall_M;
  logic             flush_D;
  logic             flush_E;
  logic [1:0]       forward_a;
  logic [1:0]       forward_b;
  logic             mem_timeout;
  logic [CNT_W-1:0] stall_cycles;
  logic [CNT_W-1:0] flush_events;

  modport master (
    output IF_ID_rs1, IF_ID_rs2, ID_rs1, ID_rs2, ID_EX_RD, ID_EX_regwrite, ID_EX_wb_sel,
           EX_MEM_RD, EX_MEM_regwrite, EX_MEM_memreq, dmem_ready, MEM_WB_RD,
           MEM_WB_regwrite, branch_taken,
    input  stall_F, stall_D, stall_E, stall_M, flush_D, flush_E, forward_a, forward_b,
           mem_timeout, stall_cycles, flush_events
  );

  modport slave (
    input  IF_ID_rs1, IF_ID_rs2, ID_rs1, ID_rs2, ID_EX_RD, ID_EX_regwrite, ID_EX_wb_sel,
           EX_MEM_RD, EX_MEM_regwrite, EX_MEM_memreq, dmem_ready, MEM_WB_RD,
           MEM_WB_regwrite, branch_taken,
    output stall_F, stall_D, stall_E, stall_M, flush_D, flush_E, forward_a, forward_b,
           mem_timeout, stall_cycles, flush_events
  );
endinterface

// File: rtl/hazard_controller.sv
// Stall/flush/forward sequencing for the 5-stage RV32I pipeline, with a data-memory wait watchdog.
//   state      | meaning
//   S_RUN      | normal issue; hazards resolved by priority memstall > branch > load-use
//   S_MEM_WAIT | data memory busy, whole pipeline frozen, wait cycles being counted
//   S_ERROR    | memory never answered; pipeline frozen until reset
module hazard_controller #(
  parameter int CNT_W   = 32,
  parameter int TIMEOUT = 16,
  parameter int TO_W    = 8
) (
  input  logic         clk,
  input  logic         rst,
  hazard_controller_if.slave hz
);

  localparam logic [1:0] S_RUN      = 2'd0;
  localparam logic [1:0] S_MEM_WAIT = 2'd1;
  localparam logic [1:0] S_ERROR    = 2'd2;

  logic [1:0]       r_state;
  logic [1:0]       w_state_nxt;
  logic [TO_W-1:0]  r_wait_cnt;
  logic [TO_W-1:0]  w_wait_cnt_nxt;
  logic             r_mem_timeout;
  logic             w_mem_timeout_nxt;
  logic [CNT_W-1:0] r_stall_cycles;
  logic [CNT_W-1:0] r_flush_events;

  logic             w_memstall;
  logic             w_loaduse;
  logic             w_stall_f;
  logic             w_stall_d;
  logic             w_stall_e;
  logic             w_stall_m;
  logic             w_flush_d;
  logic             w_flush_e;
  logic [1:0]       w_fwd_a;
  logic [1:0]       w_fwd_b;

  assign w_memstall = hz.EX_MEM_memreq & ~hz.dmem_ready & (r_state != S_ERROR);

  assign w_loaduse = hz.ID_EX_wb_sel & hz.ID_EX_regwrite & (hz.ID_EX_RD != 5'd0) &
                     ((hz.ID_EX_RD == hz.IF_ID_rs1) | (hz.ID_EX_RD == hz.IF_ID_rs2));

  always_comb begin
    w_stall_f = 1'b0;
    w_stall_d = 1'b0;
    w_stall_e = 1'b0;
    w_stall_m = 1'b0;
    w_flush_d = 1'b0;
    w_flush_e = 1'b0;
    if (rst) begin
      w_stall_f = 1'b0;
    end else if (r_state == S_ERROR || w_memstall) begin
      w_stall_f = 1'b1;
      w_stall_d = 1'b1;
      w_stall_e = 1'b1;
      w_stall_m = 1'b1;
    end else if (hz.branch_taken) begin
      // the load-use victim sits in ID and is squashed by this flush anyway
      w_flush_d = 1'b1;
      w_flush_e = 1'b1;
    end else if (w_loaduse) begin
      w_stall_f = 1'b1;
      w_stall_d = 1'b1;
      w_flush_e = 1'b1;
    end
  end

  always_comb begin
    w_fwd_a = 2'b00;
    w_fwd_b = 2'b00;
    if (!rst) begin
      if (hz.EX_MEM_regwrite && hz.EX_MEM_RD != 5'd0 && hz.EX_MEM_RD == hz.ID_rs1)
        w_fwd_a = 2'b10;
      else if (hz.MEM_WB_regwrite && hz.MEM_WB_RD != 5'd0 && hz.MEM_WB_RD == hz.ID_rs1)
        w_fwd_a = 2'b01;
      if (hz.EX_MEM_regwrite && hz.EX_MEM_RD != 5'd0 && hz.EX_MEM_RD == hz.ID_rs2)
        w_fwd_b = 2'b10;
      else if (hz.MEM_WB_regwrite && hz.MEM_WB_RD != 5'd0 && hz.MEM_WB_RD == hz.ID_rs2)
        w_fwd_b = 2'b01;
    end
  end

  always_comb begin
    w_state_nxt       = r_state;
    w_wait_cnt_nxt    = r_wait_cnt;
    w_mem_timeout_nxt = r_mem_timeout;
    case (r_state)
      S_RUN: begin
        if (w_memstall) begin
          w_state_nxt    = S_MEM_WAIT;
          w_wait_cnt_nxt = TO_W'(1);
        end
      end
      S_MEM_WAIT: begin
        if (!hz.EX_MEM_memreq || hz.dmem_ready) begin
          w_state_nxt    = S_RUN;
          w_wait_cnt_nxt = '0;
        end else if (r_wait_cnt == TO_W'(TIMEOUT)) begin
          w_state_nxt       = S_ERROR;
          w_mem_timeout_nxt = 1'b1;
        end else begin
          w_wait_cnt_nxt = r_wait_cnt + TO_W'(1);
        end
      end
      S_ERROR: begin
        w_state_nxt = S_ERROR;
      end
      default: begin
        w_state_nxt    = S_RUN;
        w_wait_cnt_nxt = '0;
      end
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_state       <= S_RUN;
      r_wait_cnt    <= '0;
      r_mem_timeout <= 1'b0;
    end else begin
      r_state       <= w_state_nxt;
      r_wait_cnt    <= w_wait_cnt_nxt;
      r_mem_timeout <= w_mem_timeout_nxt;
    end
  end

  // performance counters stick at all-ones rather than wrapping
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_stall_cycles <= '0;
      r_flush_events <= '0;
    end else begin
      if (w_stall_f && r_stall_cycles != '1)
        r_stall_cycles <= r_stall_cycles + CNT_W'(1);
      if (w_flush_d && r_flush_events != '1)
        r_flush_events <= r_flush_events + CNT_W'(1);
    end
  end

  assign hz.stall_F      = w_stall_f;
  assign hz.stall_D      = w_stall_d;
  assign hz.stall_E      = w_stall_e;
  assign hz.stall_M      = w_stall_m;
  assign hz.flush_D      = w_flush_d;
  assign hz.flush_E      = w_flush_e;
  assign hz.forward_a    = w_fwd_a;
  assign hz.forward_b    = w_fwd_b;
  assign hz.mem_timeout  = r_mem_timeout;
  assign hz.stall_cycles = r_stall_cycles;
  assign hz.flush_events = r_flush_events;

endmodule
